// File: rtl/eq_pkg.sv
// Shared definitions for the equaliser datapath: default widths, band count,
// sample limits and the mixer state encoding.
package eq_pkg;

    localparam int unsigned WD_SAMPLE   = 24;
    localparam int unsigned N_BANDS_DEF = 4;

    localparam logic signed [WD_SAMPLE-1:0] SAMPLE_MAX = {1'b0, {(WD_SAMPLE-1){1'b1}}};
    localparam logic signed [WD_SAMPLE-1:0] SAMPLE_MIN = {1'b1, {(WD_SAMPLE-1){1'b0}}};

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mixer_state_t;

endpackage

// File: rtl/sat_clip.sv
// Combinational saturation of a wide signed value to a narrower signed width,
// with a flag raised whenever the value had to be clamped.
module sat_clip #(
    parameter int unsigned WD_ACC = 26,
    parameter int unsigned WD_OUT = 24
) (
    input  logic signed [WD_ACC-1:0] acc_in,
    output logic signed [WD_OUT-1:0] sat_out,
    output logic                     clip_out
);

    // Limits expressed at accumulator width so the compare needs no extension.
    localparam logic signed [WD_ACC-1:0] LIM_MAX = {{(WD_ACC-WD_OUT+1){1'b0}}, {(WD_OUT-1){1'b1}}};
    localparam logic signed [WD_ACC-1:0] LIM_MIN = {{(WD_ACC-WD_OUT+1){1'b1}}, {(WD_OUT-1){1'b0}}};

    always_comb begin
        sat_out  = acc_in[WD_OUT-1:0];
        clip_out = 1'b0;
        if (acc_in > LIM_MAX) begin
            sat_out  = {1'b0, {(WD_OUT-1){1'b1}}};
            clip_out = 1'b1;
        end else if (acc_in < LIM_MIN) begin
            sat_out  = {1'b1, {(WD_OUT-1){1'b0}}};
            clip_out = 1'b1;
        end
    end

endmodule

// File: rtl/band_mixer.sv
// Serially sums N_BANDS band samples per period, saturates and hands one mixed sample downstream.
// Optional BAND_MIXER_CLIP_CNT_EN adds a saturating 16-bit clipped-sample counter (clip_cnt_out).
module band_mixer
    import eq_pkg::*;
#(
    parameter int unsigned WD_IN   = WD_SAMPLE,
    parameter int unsigned WD_OUT  = WD_SAMPLE,
    parameter int unsigned N_BANDS = N_BANDS_DEF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       band_valid_in,
    output logic                       band_ready_out,
    input  logic signed [WD_IN-1:0]    band_data_in,
    output logic [$clog2(N_BANDS)-1:0] band_idx_out,
    output logic                       mix_valid_out,
    input  logic                       mix_ready_in,
    output logic signed [WD_OUT-1:0]   mix_data_out,
    output logic                       clip_out
`ifdef BAND_MIXER_CLIP_CNT_EN
    ,
    output logic [15:0]                clip_cnt_out
`endif
);

    localparam int unsigned WD_ACC = WD_IN + $clog2(N_BANDS);
    localparam int unsigned WD_IDX = $clog2(N_BANDS);
    localparam logic [WD_IDX-1:0] LAST_IDX = WD_IDX'(N_BANDS - 1);

    mixer_state_t              state;
    logic signed [WD_ACC-1:0]  acc;
    logic signed [WD_ACC-1:0]  sum;
    logic signed [WD_OUT-1:0]  sum_sat;
    logic                      sum_clip;
    logic                      band_hs;

    assign band_ready_out = (state == ACCUM) && !rst_in;
    assign band_hs        = band_valid_in && band_ready_out;
    assign sum            = acc + {{(WD_ACC-WD_IN){band_data_in[WD_IN-1]}}, band_data_in};

    sat_clip #(
        .WD_ACC (WD_ACC),
        .WD_OUT (WD_OUT)
    ) u_sat_clip (
        .acc_in   (sum),
        .sat_out  (sum_sat),
        .clip_out (sum_clip)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ACCUM;
            acc           <= '0;
            band_idx_out  <= '0;
            mix_valid_out <= 1'b0;
            mix_data_out  <= '0;
            clip_out      <= 1'b0;
`ifdef BAND_MIXER_CLIP_CNT_EN
            clip_cnt_out  <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (band_hs) begin
                        if (band_idx_out == LAST_IDX) begin
                            mix_data_out  <= sum_sat;
                            clip_out      <= sum_clip;
                            mix_valid_out <= 1'b1;
                            acc           <= '0;
                            band_idx_out  <= '0;
                            state         <= HOLD;
`ifdef BAND_MIXER_CLIP_CNT_EN
                            if (sum_clip && (clip_cnt_out != 16'hFFFF)) begin
                                clip_cnt_out <= clip_cnt_out + 16'd1;
                            end
`endif
                        end else begin
                            acc          <= sum;
                            band_idx_out <= band_idx_out + WD_IDX'(1);
                        end
                    end
                end
                HOLD: begin
                    if (mix_ready_in) begin
                        mix_valid_out <= 1'b0;
                        state         <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_band_mixer.sv
// Scoreboard bench for band_mixer: directed frames push expected mixes, a monitor pops on handshake.
// Counter checks are compiled in only with BAND_MIXER_CLIP_CNT_EN.
module tb_band_mixer;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               band_valid_in;
    logic               band_ready_out;
    logic signed [23:0] band_data_in;
    logic [1:0]         band_idx_out;
    logic               mix_valid_out;
    logic               mix_ready_in;
    logic signed [23:0] mix_data_out;
    logic               clip_out;
`ifdef BAND_MIXER_CLIP_CNT_EN
    logic [15:0]        clip_cnt_out;
`endif

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];  // {clip, data}

    always #5 clk_in = ~clk_in;

    band_mixer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .band_valid_in  (band_valid_in),
        .band_ready_out (band_ready_out),
        .band_data_in   (band_data_in),
        .band_idx_out   (band_idx_out),
        .mix_valid_out  (mix_valid_out),
        .mix_ready_in   (mix_ready_in),
        .mix_data_out   (mix_data_out),
        .clip_out       (clip_out)
`ifdef BAND_MIXER_CLIP_CNT_EN
        ,
        .clip_cnt_out   (clip_cnt_out)
`endif
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: inputs change just after posedge, so a negedge sample sees the coming handshake.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && mix_valid_out && mix_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mix: got %0d, expected no output", mix_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("mix_data", longint'(mix_data_out), longint'($signed(e[23:0])));
                    check("clip", longint'(clip_out), longint'(e[24]));
                end
            end
        end
    end

    task automatic send_band(input logic signed [23:0] d, input int idx);
        bit hs = 0;
        band_valid_in = 1'b1;
        band_data_in  = d;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_in);
            hs = band_ready_out;
            if (hs) check("band_idx", longint'(band_idx_out), longint'(idx));
            @(posedge clk_in);
            #1;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL band_timeout: got no handshake, expected one within 50 cycles");
        end
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d,
                              input int exp_data, input bit exp_clip);
        exp_q.push_back({exp_clip, 24'(exp_data)});
        send_band(24'(a), 0);
        send_band(24'(b), 1);
        send_band(24'(c), 2);
        send_band(24'(d), 3);
        band_valid_in = 1'b0;
        check("valid_latency", longint'(mix_valid_out), 1);
        check("idx_wrap", longint'(band_idx_out), 0);
        if (mix_ready_in) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        band_valid_in = 1'b0;
        band_data_in  = '0;
        mix_ready_in  = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ready", longint'(band_ready_out), 0);
        check("rst_valid", longint'(mix_valid_out), 0);
        check("rst_data", longint'(mix_data_out), 0);
        check("rst_clip", longint'(clip_out), 0);
        check("rst_idx", longint'(band_idx_out), 0);
        rst_in = 1'b0;
        #1;
        check("ready_after_rst", longint'(band_ready_out), 1);

        send_frame(100, -50, 25, 1, 76, 0);

        // Output stalled for 5 cycles while upstream keeps offering a band.
        mix_ready_in = 1'b0;
        send_frame(1, 1, 1, 2, 5, 0);
        band_valid_in = 1'b1;
        band_data_in  = 24'sd77;
        repeat (5) begin
            @(negedge clk_in);
            check("stall_ready", longint'(band_ready_out), 0);
            check("stall_valid", longint'(mix_valid_out), 1);
            check("stall_data", longint'(mix_data_out), 5);
            @(posedge clk_in);
            #1;
        end
        mix_ready_in  = 1'b1;
        band_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("post_stall_idx", longint'(band_idx_out), 0);
        check("post_stall_ready", longint'(band_ready_out), 1);
        send_frame(1, 2, 3, 4, 10, 0);

        // Partial frame dropped by a one-cycle reset.
        send_band(24'sd10, 0);
        send_band(24'sd20, 1);
        band_valid_in = 1'b0;
        rst_in        = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("mid_rst_idx", longint'(band_idx_out), 0);
        send_frame(1, 2, 3, 4, 10, 0);

        send_frame(3000000, 3000000, 3000000, 3000000, 8388607, 1);
        send_frame(-3000000, -3000000, -3000000, -3000000, -8388608, 1);
        send_frame(8388607, 0, 0, 0, 8388607, 0);
        send_frame(-8388608, 0, 0, 0, -8388608, 0);
        send_frame(8388607, 1, 0, 0, 8388607, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_in);
        #1;
        check("scoreboard_drained", longint'(exp_q.size()), 0);
`ifdef BAND_MIXER_CLIP_CNT_EN
        check("clip_cnt", longint'(clip_cnt_out), 3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/band_mixer.md
Name: band_mixer

Overview:
- Downstream neighbour of the per-band gain stage.
- Accepts the N_BANDS gain-adjusted band samples of one audio sample period serially, one per handshake.
- Sums them in a widened accumulator, saturates the sum to WD_OUT bits and presents one mixed sample with a valid/ready handshake to the output path (I2S/codec transmitter).
- Drives the index of the band it expects next, so the upstream band mux and gain-select logic can be steered.

Parameters:
- WD_IN, 24, signed band sample width.
- WD_OUT, 24, signed mixed output width; must be <= WD_ACC.
- N_BANDS, 4, bands per sample period; must be >= 2.
- (derived localparam) WD_ACC = WD_IN + $clog2(N_BANDS), accumulator width; the sum can never overflow it.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- band_valid_in  input  1  band_data_in is valid this cycle.
- band_ready_out  output  1  mixer accepts a band sample this cycle.
- band_data_in  input  WD_IN  signed band sample.
- band_idx_out  output  $clog2(N_BANDS)  index of the band expected at the next handshake.
- mix_valid_out  output  1  mix_data_out holds a valid mixed sample.
- mix_ready_in  input  1  downstream consumes mix_data_out.
- mix_data_out  output  WD_OUT  signed saturated sum.
- clip_out  output  1  current mix_data_out was saturated; qualified by mix_valid_out.

Behaviour:
- One clock; reset is synchronous and active-high (clk_in, rst_in).
- Reset values:
  - state = ACCUM; acc = 0; band_idx_out = 0; band_ready_out = 1 after reset deasserts.
  - mix_valid_out = 0; mix_data_out = 0; clip_out = 0.
  - Reset while in rst_in forces band_ready_out = 0.
- States: ACCUM, HOLD.
- ACCUM:
  - band_ready_out = 1.
  - Band handshake = band_valid_in && band_ready_out.
  - On handshake with band_idx_out < N_BANDS-1: acc <= acc + sign-extended band_data_in; band_idx_out increments.
  - On handshake with band_idx_out == N_BANDS-1:
    - final = acc + sign-extended band_data_in.
    - mix_data_out <= sat(final); clip_out <= (final outside the WD_OUT range).
    - mix_valid_out <= 1; acc <= 0; band_idx_out <= 0; go to HOLD.
  - No handshake: all state is held. Gaps between band samples are allowed.
- HOLD:
  - band_ready_out = 0.
  - mix_data_out and clip_out are stable while mix_valid_out = 1 and mix_ready_in = 0.
  - On mix_ready_in = 1: mix_valid_out <= 0; go to ACCUM. mix_data_out keeps its last value.
- Latency and throughput:
  - mix_valid_out rises 1 cycle after the last band handshake.
  - Minimum period is N_BANDS + 1 cycles per mixed sample.
- Saturation:
  - sat(x) = 2^(WD_OUT-1)-1 if x > that; -2^(WD_OUT-1) if x < that; otherwise x truncated to WD_OUT bits.
  - A sum exactly equal to a limit is not a clip.
- Boundary conditions:
  - band_valid_in in HOLD is ignored; the upstream must hold its data.
  - Reset mid-frame discards the partial sum and restarts at band 0.
  - Reset in HOLD drops the pending output.
- band_idx_out is registered state, not a combinational function of the inputs.

Optional Feature:
- Macro BAND_MIXER_CLIP_CNT_EN.
- Defined:
  - Adds output port clip_cnt_out, 16 bits.
  - Increments by 1 on every mixed sample produced with a clip, i.e. on the transition into HOLD with a saturated sum.
  - Saturates at 16'hFFFF; cleared only by rst_in.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package eq_pkg:
  - default sample width (24) and N_BANDS (4).
  - mixer state enum typedef (ACCUM, HOLD).
  - sample max/min localparams.
- Sub-module sat_clip:
  - Combinational: WD_ACC signed in, WD_OUT signed out plus a clip flag.
  - Reused later by other widening stages.
- The accumulator, counter and FSM stay in band_mixer.

Test Plan:
- Bands 100, -50, 25, 1 back-to-back, mix_ready_in = 1 -> mix_data_out = 76 and clip_out = 0, one cycle after the 4th handshake; band_idx_out sequence 0,1,2,3,0.
- Four bands of 3000000 -> mix_data_out = 8388607 (0x7FFFFF), clip_out = 1. Four bands of -3000000 -> -8388608, clip_out = 1.
- Sum exactly 8388607 (8388607, 0, 0, 0) -> output 8388607, clip_out = 0.
- mix_ready_in held 0 for 5 cycles after a result, with band_valid_in = 1 throughout:
  - band_ready_out = 0 and mix_data_out stable for those cycles.
  - No band consumed.
  - Next frame starts at band 0 the cycle after mix_ready_in = 1.
- rst_in asserted for 1 cycle after 2 of 4 bands (10, 20), then bands 1, 2, 3, 4 -> output 10, with no contribution from the discarded bands.
- With BAND_MIXER_CLIP_CNT_EN defined: three clipping frames and one clean frame -> clip_cnt_out = 3. Rerun with the macro undefined: the build has no clip_cnt_out port.
